// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the ID-stage hazard detector
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } mc_state_t;

    localparam int REG_ZERO = 0;
    localparam int MC_CNT_W = 4;

endpackage

// File: rtl/mc_stall_seq.sv
// rtl/mc_stall_seq.sv - multi-cycle op stall sequencer (IDLE -> BUSY -> RELEASE)
module mc_stall_seq
    import hazard_pkg::*;
#(
    parameter int MC_LATENCY = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic mc_start_ok,
    output logic mc_stall,
    output logic mc_busy
);

    // First stall cycle is spent in IDLE, so BUSY counts down MC_LATENCY-1 cycles.
    localparam logic [MC_CNT_W-1:0] CNT_INIT =
        (MC_LATENCY > 1) ? MC_CNT_W'(MC_LATENCY - 2) : '0;

    mc_state_t             state_q, state_d;
    logic [MC_CNT_W-1:0]   cnt_q, cnt_d;
    logic                  busy_q, busy_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mc_stall = 1'b0;
        case (state_q)
            IDLE: begin
                mc_stall = mc_start_ok;
                if (mc_start_ok) begin
                    if (MC_LATENCY == 1) begin
                        state_d = RELEASE;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                mc_stall = 1'b1;
                if (cnt_q == '0) begin
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q - MC_CNT_W'(1);
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign mc_busy = busy_q;

endmodule

// File: rtl/hazard_detect_unit.sv
// rtl/hazard_detect_unit.sv - ID-stage load-use / multi-cycle stall and branch flush requests
// Optional stall-cycle performance counter enabled by defining HAZ_PERF_EN.
module hazard_detect_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MC_LATENCY = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_idValid,
    input  logic [REG_ADDR_W-1:0] io_idRs1,
    input  logic [REG_ADDR_W-1:0] io_idRs2,
    input  logic                  io_idUseRs1,
    input  logic                  io_idUseRs2,
    input  logic                  io_idMcStart,
    input  logic                  io_idBranchTaken,
    input  logic [REG_ADDR_W-1:0] io_exeRd,
    input  logic                  io_exeRegWrite,
    input  logic                  io_exeMemRead,
    output logic                  io_stallReqOfID,
    output logic                  io_flushReqOfID,
    output logic                  io_mcBusy
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0]           io_perfStallCycles
`endif
);

    logic lu_haz;
    logic rs1_hit;
    logic rs2_hit;
    logic mc_start_ok;
    logic mc_stall;
    logic mc_busy;
    logic stall;

    assign rs1_hit = io_idUseRs1 && (io_idRs1 == io_exeRd);
    assign rs2_hit = io_idUseRs2 && (io_idRs2 == io_exeRd);

    assign lu_haz = io_idValid && io_exeMemRead && io_exeRegWrite &&
                    (io_exeRd != REG_ADDR_W'(REG_ZERO)) && (rs1_hit || rs2_hit);

    // mc_busy is exactly "sequencer not IDLE"; load-use wins over starting an op.
    assign mc_start_ok = io_idValid && io_idMcStart && !lu_haz && !mc_busy;

    mc_stall_seq #(
        .MC_LATENCY (MC_LATENCY)
    ) u_mc_stall_seq (
        .clock       (clock),
        .reset       (reset),
        .mc_start_ok (mc_start_ok),
        .mc_stall    (mc_stall),
        .mc_busy     (mc_busy)
    );

    // Outputs are held low for the whole reset pulse, not just from the next edge.
    assign stall           = !reset && ((lu_haz && !mc_busy) || mc_stall);
    assign io_stallReqOfID = stall;
    assign io_flushReqOfID = !reset && io_idValid && io_idBranchTaken;
    assign io_mcBusy       = mc_busy;

`ifdef HAZ_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (stall && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign io_perfStallCycles = perf_q;
`endif

endmodule

// File: tb/tb_hazard_detect_unit.sv
// tb/tb_hazard_detect_unit.sv - scoreboard bench for hazard_detect_unit (MC_LATENCY=4)
module tb_hazard_detect_unit;

    logic       clock;
    logic       reset;
    logic       io_idValid;
    logic [4:0] io_idRs1;
    logic [4:0] io_idRs2;
    logic       io_idUseRs1;
    logic       io_idUseRs2;
    logic       io_idMcStart;
    logic       io_idBranchTaken;
    logic [4:0] io_exeRd;
    logic       io_exeRegWrite;
    logic       io_exeMemRead;
    logic       io_stallReqOfID;
    logic       io_flushReqOfID;
    logic       io_mcBusy;
`ifdef HAZ_PERF_EN
    logic [31:0] io_perfStallCycles;
`endif

    hazard_detect_unit #(
        .REG_ADDR_W (5),
        .MC_LATENCY (4)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .io_idValid       (io_idValid),
        .io_idRs1         (io_idRs1),
        .io_idRs2         (io_idRs2),
        .io_idUseRs1      (io_idUseRs1),
        .io_idUseRs2      (io_idUseRs2),
        .io_idMcStart     (io_idMcStart),
        .io_idBranchTaken (io_idBranchTaken),
        .io_exeRd         (io_exeRd),
        .io_exeRegWrite   (io_exeRegWrite),
        .io_exeMemRead    (io_exeMemRead),
        .io_stallReqOfID  (io_stallReqOfID),
        .io_flushReqOfID  (io_flushReqOfID),
        .io_mcBusy        (io_mcBusy)
`ifdef HAZ_PERF_EN
        ,
        .io_perfStallCycles (io_perfStallCycles)
`endif
    );

    typedef struct {
        string       nm;
        logic        s;
        logic        f;
        logic        b;
        logic        pchk;
        logic [31:0] p;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic vec(input string nm, input logic rst, input logic v,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2, input logic mc, input logic br,
                       input logic [4:0] erd, input logic erw, input logic emr,
                       input logic es, input logic ef, input logic eb,
                       input logic pchk = 1'b0, input logic [31:0] ep = 32'd0);
        exp_t e;
        @(posedge clock);
        #1;
        reset            = rst;
        io_idValid       = v;
        io_idRs1         = r1;
        io_idRs2         = r2;
        io_idUseRs1      = u1;
        io_idUseRs2      = u2;
        io_idMcStart     = mc;
        io_idBranchTaken = br;
        io_exeRd         = erd;
        io_exeRegWrite   = erw;
        io_exeMemRead    = emr;
        e.nm = nm; e.s = es; e.f = ef; e.b = eb; e.pchk = pchk; e.p = ep;
        q.push_back(e);
    endtask

    // Multi-cycle op vector with no load in EXE.
    task automatic mcv(input string nm, input logic v, input logic mc,
                       input logic es, input logic eb,
                       input logic pchk = 1'b0, input logic [31:0] ep = 32'd0);
        vec(nm, 1'b0, v, 5'd1, 5'd2, 1'b1, 1'b1, mc, 1'b0, 5'd0, 1'b0, 1'b0,
            es, 1'b0, eb, pchk, ep);
    endtask

    // Monitor: one expected response per cycle, sampled at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if (io_stallReqOfID !== e.s || io_flushReqOfID !== e.f || io_mcBusy !== e.b) begin
                    n_err++;
                    $display("FAIL %s: stall/flush/busy got %b%b%b want %b%b%b", e.nm,
                             io_stallReqOfID, io_flushReqOfID, io_mcBusy, e.s, e.f, e.b);
                end
`ifdef HAZ_PERF_EN
                if (e.pchk && io_perfStallCycles !== e.p) begin
                    n_err++;
                    $display("FAIL %s_perf: got %h want %h", e.nm, io_perfStallCycles, e.p);
                end
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        io_idValid = 0; io_idRs1 = 0; io_idRs2 = 0; io_idUseRs1 = 0; io_idUseRs2 = 0;
        io_idMcStart = 0; io_idBranchTaken = 0; io_exeRd = 0; io_exeRegWrite = 0;
        io_exeMemRead = 0;

        vec("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'd0);

        // Single MUL held: 4 stall cycles, RELEASE, busy cycles 2..5
        mcv("mc_c1", 1, 1, 1, 0);
        mcv("mc_c2", 1, 1, 1, 1);
        mcv("mc_c3", 1, 1, 1, 1);
        mcv("mc_c4", 1, 1, 1, 1);
        mcv("mc_c5_release", 1, 1, 0, 1, 1, 32'd4);
        mcv("mc_idle", 1, 0, 0, 0, 1, 32'd4);

        // Load-use
        vec("lu_rs1",    0, 1, 5, 0, 1, 0, 0, 0, 5, 1, 1, 1, 0, 0);
        vec("lu_rd0",    0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        vec("lu_nouse",  0, 1, 5, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
        vec("lu_rs2",    0, 1, 0, 5, 0, 1, 0, 0, 5, 1, 1, 1, 0, 0);
        vec("lu_both",   0, 1, 5, 5, 1, 1, 0, 0, 5, 1, 1, 1, 0, 0);
        vec("lu_noload", 0, 1, 5, 5, 1, 1, 0, 0, 5, 1, 0, 0, 0, 0);
        vec("lu_nowr",   0, 1, 5, 5, 1, 1, 0, 0, 5, 0, 1, 0, 0, 0);
        vec("lu_noval",  0, 0, 5, 5, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0);

        // Branch flush
        vec("br_taken",  0, 1, 1, 2, 1, 1, 0, 1, 5, 1, 1, 0, 1, 0);
        vec("br_lu",     0, 1, 5, 2, 1, 1, 0, 1, 5, 1, 1, 1, 1, 0);
        vec("br_noval",  0, 0, 5, 2, 1, 1, 0, 1, 5, 1, 1, 0, 0, 0);

        // Back-to-back ops: 1111 0 1111 0
        mcv("b2b_c1", 1, 1, 1, 0);
        mcv("b2b_c2", 1, 1, 1, 1);
        mcv("b2b_c3", 1, 1, 1, 1);
        mcv("b2b_c4", 1, 1, 1, 1);
        mcv("b2b_c5", 1, 1, 0, 1);
        mcv("b2b_c6", 1, 1, 1, 0);
        mcv("b2b_c7", 1, 1, 1, 1);
        mcv("b2b_c8", 1, 1, 1, 1);
        mcv("b2b_c9", 1, 1, 1, 1);
        mcv("b2b_c10", 1, 1, 0, 1);
        mcv("b2b_idle", 1, 0, 0, 0);

        // Multi-cycle op that is also load-dependent: 1 load-use stall first
        vec("lumc_lu", 0, 1, 5, 0, 1, 0, 1, 0, 5, 1, 1, 1, 0, 0);
        mcv("lumc_c1", 1, 1, 1, 0);
        mcv("lumc_c2", 1, 1, 1, 1);
        mcv("lumc_c3", 1, 1, 1, 1);
        mcv("lumc_c4", 1, 1, 1, 1);
        mcv("lumc_c5", 1, 1, 0, 1);
        mcv("lumc_idle", 1, 0, 0, 0);

        // idValid drops mid-sequence: sequence still completes
        mcv("vdrop_c1", 1, 1, 1, 0);
        mcv("vdrop_c2", 0, 1, 1, 1);
        mcv("vdrop_c3", 0, 0, 1, 1);
        mcv("vdrop_c4", 0, 0, 1, 1);
        mcv("vdrop_c5", 0, 0, 0, 1);
        mcv("vdrop_idle", 0, 0, 0, 0);

        // Asynchronous reset mid-BUSY, then a full sequence
        mcv("rmid_c1", 1, 1, 1, 0);
        mcv("rmid_c2", 1, 1, 1, 1);
        vec("rmid_rst", 1, 1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        mcv("rmid_full_c1", 1, 1, 1, 0);
        mcv("rmid_full_c2", 1, 1, 1, 1);
        mcv("rmid_full_c3", 1, 1, 1, 1);
        mcv("rmid_full_c4", 1, 1, 1, 1);
        mcv("rmid_full_c5", 1, 1, 0, 1);
        mcv("rmid_full_idle", 1, 0, 0, 0, 1, 32'd4);

`ifdef HAZ_PERF_EN
        while (q.size() > 0) @(negedge clock);
        @(negedge clock);
        force dut.perf_q = 32'hFFFF_FFFE;
        #1;
        release dut.perf_q;
        vec("sat_c1", 0, 1, 5, 0, 1, 0, 0, 0, 5, 1, 1, 1, 0, 0, 1, 32'hFFFF_FFFE);
        vec("sat_c2", 0, 1, 5, 0, 1, 0, 0, 0, 5, 1, 1, 1, 0, 0, 1, 32'hFFFF_FFFF);
        vec("sat_c3", 0, 1, 5, 0, 1, 0, 0, 0, 5, 1, 1, 1, 0, 0, 1, 32'hFFFF_FFFF);
        mcv("sat_idle", 1, 0, 0, 0, 1, 32'hFFFF_FFFF);
`endif

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clock);
        @(posedge clock);
        if (q.size() > 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
